// File: rtl/sram_burst_controller.sv
// Burst master for single_port_sram: one command at a time. Reads reach rd_valid 3 cycles after accept.
// wr_ready stalls writes word by word; rd_ready backpressure holds read issue through FIFO credits.
module sbc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  output logic                       pop_vld,
  input  logic                       pop_rdy,
  output logic [W-1:0]               pop_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  assign pop_vld = (count != '0);
  assign pop     = pop_vld & pop_rdy;
  assign pop_dat = mem[rd_ptr];

  // The producer never pushes into a full FIFO, so no full guard here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push_vld) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end
endmodule

module sram_burst_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  sram_oe
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, WLAST, READ} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic                  iss_v;
  logic                  iss_v_d;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           in_flight;
  logic                  wr_hs;
  logic                  can_issue;
  logic                  rd_last;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign wr_hs     = wr_valid & wr_ready;
  assign sram_data = sram_we ? sram_wdata : {DATA_WIDTH{1'bz}};

  // Every issued-but-unpopped word holds a FIFO slot until it is handed off.
  assign in_flight = (CW+1)'(fifo_count) + (CW+1)'(iss_v) + (CW+1)'(iss_v_d);
  assign can_issue = (remaining != '0) && (in_flight < (CW+1)'(FIFO_DEPTH));
  assign rd_last   = (remaining == '0) && !iss_v && !iss_v_d &&
                     ((fifo_count == '0) || ((fifo_count == CW'(1)) && rd_ready));

  sbc_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (iss_v_d),
    .push_dat (sram_data),
    .pop_vld  (rd_valid),
    .pop_rdy  (rd_ready),
    .pop_dat  (rd_data),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
      iss_v      <= 1'b0;
      iss_v_d    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      iss_v   <= 1'b0;
      iss_v_d <= iss_v;
      case (state)
        IDLE: begin
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          sram_oe <= 1'b0;
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else if (cmd_write) begin
              state <= WRITE;
            end else begin
              // First read goes out on the accept edge to meet the 3-cycle latency.
              state     <= READ;
              sram_addr <= cmd_addr;
              sram_cs   <= 1'b1;
              sram_oe   <= 1'b1;
              iss_v     <= 1'b1;
              addr      <= cmd_addr + ADDR_WIDTH'(1);
              remaining <= cmd_len - LEN_WIDTH'(1);
            end
          end
        end
        WRITE: begin
          sram_oe <= 1'b0;
          if (wr_hs) begin
            sram_addr  <= addr;
            sram_wdata <= wr_data;
            sram_cs    <= 1'b1;
            sram_we    <= 1'b1;
            addr       <= addr + ADDR_WIDTH'(1);
            remaining  <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= WLAST;
          end else begin
            sram_cs <= 1'b0;
            sram_we <= 1'b0;
          end
        end
        WLAST: begin
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          state   <= IDLE;
          done    <= 1'b1;
        end
        READ: begin
          if (rd_last) begin
            state   <= IDLE;
            sram_cs <= 1'b0;
            sram_oe <= 1'b0;
            done    <= 1'b1;
          end else if (can_issue) begin
            sram_addr <= addr;
            iss_v     <= 1'b1;
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench for sram_burst_controller with a behavioural single-port SRAM on its bus.
module tb_sram_burst_controller;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;
  logic          sram_cs;
  logic          sram_we;
  logic          sram_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_burst_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_oe   (sram_oe)
  );

  // SRAM: latches a read address at the edge, drives the word for the following cycle.
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] sram_q;
  logic          sram_drv;

  assign sram_data = sram_drv ? sram_q : {DW{1'bz}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_drv <= 1'b0;
    end else begin
      sram_drv <= sram_cs & sram_oe & ~sram_we;
      if (sram_cs && sram_oe && !sram_we) sram_q <= mem[sram_addr];
    end
  end

  always @(posedge clk) begin
    if (rst_n && sram_cs && sram_we) mem[sram_addr] <= sram_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (sram_we && (sram_oe || sram_drv)) begin
        errors++;
        $display("FAIL bus_conflict: we=%0b oe=%0b sram_drv=%0b, expected we=0 while either is 1 at %0t",
                 sram_we, sram_oe, sram_drv, $time);
      end
    end
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    int            len;
    logic [63:0]   words;   // word i lives in bits [8*i +: 8]
    int            stall;   // rd_ready held low for cycles 1..stall
    logic          poke;    // extra cmd_valid during cycles 1..2
  } vec_t;

  vec_t vecs [7];

  // Called in the negedge half of the cycle whose posedge accepts the command.
  task automatic run(input vec_t v);
    int            widx;
    int            wbus;
    int            ridx;
    int            nissue;
    int            last_hs;
    logic [AW-1:0] last_iss;
    logic [AW-1:0] ea;
    logic [DW-1:0] eb;
    logic          fin;
    widx = 0; wbus = 0; ridx = 0; nissue = 0; last_hs = 0; last_iss = '0; fin = 1'b0;
    check("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_len   = LW'(v.len);
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clk);
      cmd_valid = v.poke && (cyc <= 2);
      cmd_write = ~v.wr;
      cmd_len   = LW'(1);
      if (cmd_valid) check("ignored_cmd_busy_ready", {30'd0, busy, cmd_ready}, 32'd2);
      if (v.wr) begin
        if (sram_cs && sram_we) begin
          ea = v.addr + AW'(wbus);
          eb = v.words[8*wbus +: 8];
          check("wr_addr", {16'd0, sram_addr}, {16'd0, ea});
          check("wr_bus_data", {24'd0, sram_data}, {24'd0, eb});
          check("wr_cycle", cyc, wbus + 2);
          wbus++;
        end
        wr_valid = (widx < v.len);
        wr_data  = wr_valid ? v.words[8*widx +: 8] : '0;
        if (wr_valid && wr_ready) begin
          widx++;
          last_hs = cyc;
        end
      end else begin
        if (sram_cs && sram_oe && (nissue == 0 || sram_addr != last_iss)) begin
          ea = v.addr + AW'(nissue);
          check("rd_issue_addr", {16'd0, sram_addr}, {16'd0, ea});
          last_iss = sram_addr;
          nissue++;
        end
        if (v.stall > 0 && cyc == v.stall) begin
          check("stall_issued_words", nissue, FD);
          check("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
        end
        rd_ready = (cyc > v.stall);
        if (rd_valid && rd_ready) begin
          eb = v.words[8*ridx +: 8];
          check("rd_data", {24'd0, rd_data}, {24'd0, eb});
          if (v.stall == 0) check("rd_cycle", cyc, 3 + ridx);
          ridx++;
          last_hs = cyc;
        end
      end
      if (done) begin
        check("done_after_last_hs", cyc - last_hs, v.wr ? 2 : 1);
        check("words_moved", v.wr ? wbus : ridx, v.len);
        fin = 1'b1;
      end
    end
    if (!fin) check("burst_timeout_done_seen", 0, 1);
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    cmd_valid = 1'b0;
    if (v.wr) begin
      for (int i = 0; i < v.len; i++) begin
        ea = v.addr + AW'(i);
        eb = v.words[8*i +: 8];
        check("sram_contents", {24'd0, mem[ea]}, {24'd0, eb});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 16'h0010, len: 4, words: 64'h00000000_D4C3B2A1, stall: 0, poke: 1'b0};
    vecs[1] = '{wr: 1'b0, addr: 16'h0010, len: 4, words: 64'h00000000_D4C3B2A1, stall: 0, poke: 1'b0};
    vecs[2] = '{wr: 1'b1, addr: 16'hFFFE, len: 4, words: 64'h00000000_44332211, stall: 0, poke: 1'b0};
    vecs[3] = '{wr: 1'b0, addr: 16'hFFFE, len: 4, words: 64'h00000000_44332211, stall: 0, poke: 1'b1};
    vecs[4] = '{wr: 1'b1, addr: 16'h0100, len: 8, words: 64'h08070605_04030201, stall: 0, poke: 1'b1};
    vecs[5] = '{wr: 1'b0, addr: 16'h0100, len: 8, words: 64'h08070605_04030201, stall: 10, poke: 1'b0};
    vecs[6] = '{wr: 1'b0, addr: 16'h0012, len: 1, words: 64'h00000000_000000C3, stall: 0, poke: 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(negedge clk);
    check("rst_controls", {29'd0, sram_cs, sram_we, sram_oe}, 32'd0);
    check("rst_handshakes", {28'd0, rd_valid, wr_ready, done, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_sram_addr", {16'd0, sram_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive bursts: each starts in the cycle the previous one pulses done.
    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Zero-length command: done next cycle, no SRAM access.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_len = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("noop_done", {31'd0, done}, 32'd1);
    check("noop_idle", {29'd0, busy, sram_cs, wr_ready}, 32'd0);
    @(negedge clk);
    check("noop_done_pulse", {31'd0, done}, 32'd0);

    // Reset mid-read with two words sitting in the FIFO.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100; cmd_len = LW'(8); rd_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("pre_rst_rd_valid", {30'd0, rd_valid, sram_oe}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_controls", {29'd0, sram_cs, sram_we, sram_oe}, 32'd0);
    check("midrst_handshakes", {28'd0, rd_valid, wr_ready, done, busy}, 32'd0);
    check("midrst_sram_addr", {16'd0, sram_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", {29'd0, cmd_ready, rd_valid, sram_cs}, 32'd4);

    // Controller recovers cleanly; earlier buffered words must not leak out.
    run(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
